// File: rtl/p_encoder_rr_reg_pkg.sv
// p_encoder_rr_reg_pkg: shared mode constants for the registered priority encoder
package p_encoder_rr_reg_pkg;
  localparam int P_ENC_MODE_FIXED = 0;
  localparam int P_ENC_MODE_RR = 1;
endpackage

// File: rtl/p_encoder_core.sv
// p_encoder_core: combinational fixed-priority encoder, highest set index wins
module p_encoder_core #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] in,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan upward so the highest set bit is the last writer
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = in[i] ? W'(i) : idx;
  end
  assign any = |in;
endmodule

// File: rtl/p_encoder_rr_reg.sv
// p_encoder_rr_reg: registered fixed/round-robin priority encoder with valid/ack hold
module p_encoder_rr_reg
  import p_encoder_rr_reg_pkg::*;
#(
  parameter int N = 8,
  parameter int MODE = P_ENC_MODE_FIXED,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         v,
  output logic [N-1:0] g
);
  localparam logic [W-1:0] PMAX = W'(N - 1);
  localparam logic [W:0] NN = (W + 1)'(N);
  logic [W-1:0] y_q, y_d, ptr_q, ptr_d, s, idx, y_win;
  logic [N-1:0] g_q, g_d, rot;
  logic [W:0] sum;
  logic v_q, v_d, acc, load, any;
  assign acc = v_q & ack;
  assign load = ~v_q | ack;
  // post-accept pointer; it is also the search start for a load on the same edge
  always_comb ptr_d = (MODE == P_ENC_MODE_RR && acc) ? (y_q == '0 ? PMAX : y_q - W'(1)) : ptr_q;
  assign s = PMAX - ptr_d;
  assign rot = (req << s) | (req >> (NN - {1'b0, s}));
  p_encoder_core #(.N(N)) u_core (
    .in(rot),
    .idx(idx),
    .any(any)
  );
  assign sum = {1'b0, idx} + {1'b0, ptr_d} + (W + 1)'(1);
  assign y_win = sum >= NN ? W'(sum - NN) : W'(sum);
  // on load latch the winner (or a bubble), otherwise hold the current grant
  always_comb begin
    y_d = load ? (any ? y_win : '0) : y_q;
    v_d = load ? any : v_q;
    g_d = load ? (any ? N'(1) << y_win : '0) : g_q;
  end
  // grant and pointer state, cleared immediately by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
      g_q <= '0;
      ptr_q <= PMAX;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
    end
  assign y = y_q;
  assign v = v_q;
  assign g = g_q;
endmodule

// File: tb/tb_p_encoder_rr_reg.sv
// tb_p_encoder_rr_reg: table, corner-case and random checks of the registered priority encoder
module tb_p_encoder_rr_reg;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_a, req_b, g_a, g_b;
  logic [4:0] req_c, g_c;
  logic ack_a, ack_b, ack_c, v_a, v_b, v_c;
  logic [1:0] y_a, y_b;
  logic [2:0] y_c;
  int n_cmp = 0;
  int n_bad = 0;
  int mv[3], my[3], mp[3];
  int mn[3] = '{4, 4, 5};
  int mm[3] = '{0, 1, 1};
  typedef struct {
    logic [3:0] req;
    logic ack;
    int ya, va, yb, vb;
  } vec_t;
  vec_t tbl[23];
  int seq5[6] = '{4, 3, 2, 1, 0, 4};

  always #5 clk = ~clk;

  p_encoder_rr_reg #(.N(4), .MODE(0)) u_a (.clk(clk), .rst(rst), .req(req_a), .ack(ack_a), .y(y_a), .v(v_a), .g(g_a));
  p_encoder_rr_reg #(.N(4), .MODE(1)) u_b (.clk(clk), .rst(rst), .req(req_b), .ack(ack_b), .y(y_b), .v(v_b), .g(g_b));
  p_encoder_rr_reg #(.N(5), .MODE(1)) u_c (.clk(clk), .rst(rst), .req(req_c), .ack(ack_c), .y(y_c), .v(v_c), .g(g_c));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic [31:0] ya, input logic [31:0] va, input logic [31:0] ga, input int ey, input int ev);
    check({nm, "_v"}, va, ev);
    check({nm, "_y"}, ya, ev != 0 ? ey : 0);
    check({nm, "_g"}, ga, ev != 0 ? (1 << ey) : 0);
  endtask

  function automatic int win(input int r, input int n, input int mode, input int p);
    for (int k = 0; k < n; k++) begin
      int i;
      i = mode != 0 ? (p - k + n) % n : n - 1 - k;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input int r, input int a);
    int w;
    if (mv[d] != 0 && a != 0 && mm[d] != 0) mp[d] = my[d] == 0 ? mn[d] - 1 : my[d] - 1;
    if (mv[d] == 0 || a != 0) begin
      w = win(r, mn[d], mm[d], mp[d]);
      mv[d] = w >= 0 ? 1 : 0;
      my[d] = w >= 0 ? w : 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b0101, 1'b0, 2, 1, 2, 1};
    tbl[1]  = '{4'b1000, 1'b0, 2, 1, 2, 1};
    tbl[2]  = '{4'b1111, 1'b1, 3, 1, 1, 1};
    tbl[3]  = '{4'b1111, 1'b1, 3, 1, 0, 1};
    tbl[4]  = '{4'b1111, 1'b1, 3, 1, 3, 1};
    tbl[5]  = '{4'b1111, 1'b1, 3, 1, 2, 1};
    tbl[6]  = '{4'b1111, 1'b1, 3, 1, 1, 1};
    tbl[7]  = '{4'b1111, 1'b1, 3, 1, 0, 1};
    tbl[8]  = '{4'b1001, 1'b1, 3, 1, 3, 1};
    tbl[9]  = '{4'b1001, 1'b1, 3, 1, 0, 1};
    tbl[10] = '{4'b1001, 1'b1, 3, 1, 3, 1};
    tbl[11] = '{4'b0000, 1'b1, 0, 0, 0, 0};
    tbl[12] = '{4'b0000, 1'b1, 0, 0, 0, 0};
    tbl[13] = '{4'b0000, 1'b0, 0, 0, 0, 0};
    tbl[14] = '{4'b1111, 1'b0, 3, 1, 2, 1};
    tbl[15] = '{4'b0011, 1'b0, 3, 1, 2, 1};
    tbl[16] = '{4'b0011, 1'b1, 1, 1, 1, 1};
    tbl[17] = '{4'b0011, 1'b1, 1, 1, 0, 1};
    tbl[18] = '{4'b0000, 1'b0, 1, 1, 0, 1};
    tbl[19] = '{4'b1111, 1'b1, 3, 1, 3, 1};
    tbl[20] = '{4'b1111, 1'b1, 3, 1, 2, 1};
    tbl[21] = '{4'b1111, 1'b1, 3, 1, 1, 1};
    tbl[22] = '{4'b1111, 1'b0, 3, 1, 1, 1};

    do_reset();
    check_dut("reset_a", y_a, v_a, g_a, 0, 0);
    check_dut("reset_b", y_b, v_b, g_b, 0, 0);

    for (int i = 0; i < 23; i++) begin
      req_a = tbl[i].req; req_b = tbl[i].req;
      ack_a = tbl[i].ack; ack_b = tbl[i].ack;
      @(posedge clk);
      #1;
      check_dut($sformatf("tbl%0d_a", i), y_a, v_a, g_a, tbl[i].ya, tbl[i].va);
      check_dut($sformatf("tbl%0d_b", i), y_b, v_b, g_b, tbl[i].yb, tbl[i].vb);
    end

    #3 rst = 1'b1;
    #1;
    check_dut("async_rst_a", y_a, v_a, g_a, 0, 0);
    check_dut("async_rst_b", y_b, v_b, g_b, 0, 0);
    #2 rst = 1'b0;
    req_a = 4'b1111; req_b = 4'b1111; ack_a = 1'b0; ack_b = 1'b0;
    @(posedge clk);
    #1;
    check_dut("post_rst_a", y_a, v_a, g_a, 3, 1);
    check_dut("post_rst_b", y_b, v_b, g_b, 3, 1);

    do_reset();
    req_c = 5'b11111; ack_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_dut($sformatf("n5_seq%0d", i), y_c, v_c, g_c, seq5[i], 1);
    end

    do_reset();
    for (int d = 0; d < 3; d++) begin
      mv[d] = 0; my[d] = 0; mp[d] = mn[d] - 1;
    end
    for (int i = 0; i < 400; i++) begin
      req_a = 4'($urandom_range(0, 15));
      req_b = 4'($urandom_range(0, 15));
      req_c = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) req_a = '0;
      if ($urandom_range(0, 3) == 0) req_b = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) req_c = 5'(1 << $urandom_range(0, 4));
      ack_a = 1'($urandom_range(0, 1));
      ack_b = 1'($urandom_range(0, 2) != 0);
      ack_c = 1'($urandom_range(0, 2) != 0);
      model_step(0, int'(req_a), int'(ack_a));
      model_step(1, int'(req_b), int'(ack_b));
      model_step(2, int'(req_c), int'(ack_c));
      @(posedge clk);
      #1;
      check_dut($sformatf("rnd%0d_a", i), y_a, v_a, g_a, my[0], mv[0]);
      check_dut($sformatf("rnd%0d_b", i), y_b, v_b, g_b, my[1], mv[1]);
      check_dut($sformatf("rnd%0d_c", i), y_c, v_c, g_c, my[2], mv[2]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
